// File: rtl/recov_clk_mon_sel.sv
// Recovered-clock monitor and selector.
// Each channel's divided recovered-clock toggle is synchronised and its edges are counted
// over a fixed gate window. A channel that stays within tolerance for enough consecutive
// windows counts as locked. The selector then picks one locked channel, either automatically
// with non-preemptive failover or through a manual override.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | automatic mode, no valid selection; sel_ch holds its last value
// ST_TRACK   | automatic mode, holding a locked channel until it unlocks
// ST_MANUAL  | man_en high, sel_ch follows man_sel
module recov_clk_mon_sel #(
  parameter int NUM_CHANNEL  = 4,
  parameter int CNT_W        = 16,
  parameter int GATE_CYCLES  = 30000,
  parameter int LOCK_WINDOWS = 4,
  localparam int SEL_W = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [NUM_CHANNEL-1:0]       ch_toggle,
  input  logic [CNT_W-1:0]             cfg_expect,
  input  logic [CNT_W-1:0]             cfg_tol,
  input  logic                         man_en,
  input  logic [SEL_W-1:0]             man_sel,
  output logic [NUM_CHANNEL*CNT_W-1:0] ch_count,
  output logic [NUM_CHANNEL-1:0]       ch_locked,
  output logic                         count_valid,
  output logic [SEL_W-1:0]             sel_ch,
  output logic                         sel_valid,
  output logic                         sel_switch
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
  localparam int PAD_N  = 1 << SEL_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_MANUAL = 2'd2;

  logic [NUM_CHANNEL-1:0] sync_s0, sync_s1, sync_s2;
  logic [NUM_CHANNEL-1:0] edge_det;
  logic [GATE_W-1:0]      gate_cnt;
  logic                   gate_tc;
  logic [CNT_W-1:0]       edge_cnt  [NUM_CHANNEL];
  logic [CNT_W-1:0]       cnt_final [NUM_CHANNEL];
  logic [CNT_W:0]         deviation [NUM_CHANNEL];
  logic [GOOD_W-1:0]      good_cnt  [NUM_CHANNEL];
  logic [GOOD_W-1:0]      good_next [NUM_CHANNEL];

  logic [1:0]       state, nxt_state;
  logic [SEL_W-1:0] nxt_sel, lowest_sel;
  logic             nxt_valid, any_locked;
  logic [PAD_N-1:0] locked_pad;

  assign edge_det = sync_s1 ^ sync_s2;
  assign gate_tc  = (gate_cnt == GATE_W'(GATE_CYCLES - 1));

  // Three-flop synchroniser for the asynchronous toggles
  always_ff @(posedge aclk) begin
    if (areset) begin
      sync_s0 <= '0;
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s0 <= ch_toggle;
      sync_s1 <= sync_s0;
      sync_s2 <= sync_s1;
    end
  end

  // Free-running gate counter defining the measurement window
  always_ff @(posedge aclk) begin
    if (areset)       gate_cnt <= '0;
    else if (gate_tc) gate_cnt <= '0;
    else              gate_cnt <= gate_cnt + 1'b1;
  end

  // Saturating count including this cycle's edge, and the window quality verdict
  always_comb begin
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      cnt_final[i] = (edge_det[i] && (edge_cnt[i] != '1)) ? edge_cnt[i] + 1'b1 : edge_cnt[i];
      // one extra bit keeps the absolute difference free of wrap
      if (cnt_final[i] >= cfg_expect)
        deviation[i] = {1'b0, cnt_final[i]} - {1'b0, cfg_expect};
      else
        deviation[i] = {1'b0, cfg_expect} - {1'b0, cnt_final[i]};
      if (deviation[i] <= {1'b0, cfg_tol})
        good_next[i] = (good_cnt[i] == GOOD_W'(LOCK_WINDOWS)) ? good_cnt[i] : good_cnt[i] + 1'b1;
      else
        good_next[i] = '0;
    end
  end

  // Per-channel edge counters, cleared at the end of every window
  always_ff @(posedge aclk) begin
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      if (areset || gate_tc) edge_cnt[i] <= '0;
      else                   edge_cnt[i] <= cnt_final[i];
    end
  end

  // Window results, lock qualification and the count_valid strobe
  always_ff @(posedge aclk) begin
    if (areset) begin
      ch_count    <= '0;
      ch_locked   <= '0;
      count_valid <= 1'b0;
      for (int i = 0; i < NUM_CHANNEL; i++) good_cnt[i] <= '0;
    end else begin
      count_valid <= gate_tc;
      if (gate_tc) begin
        for (int i = 0; i < NUM_CHANNEL; i++) begin
          ch_count[i*CNT_W +: CNT_W] <= cnt_final[i];
          good_cnt[i]  <= good_next[i];
          ch_locked[i] <= (good_next[i] == GOOD_W'(LOCK_WINDOWS));
        end
      end
    end
  end

  // Next selection; locked_pad is zero above NUM_CHANNEL so out-of-range indices read unlocked
  always_comb begin
    locked_pad = '0;
    locked_pad[NUM_CHANNEL-1:0] = ch_locked;
    any_locked = |ch_locked;
    lowest_sel = '0;
    for (int i = NUM_CHANNEL - 1; i >= 0; i--) begin
      if (ch_locked[i]) lowest_sel = SEL_W'(i);
    end
    nxt_state = state;
    nxt_sel   = sel_ch;
    nxt_valid = sel_valid;
    if (man_en) begin
      nxt_state = ST_MANUAL;
      nxt_sel   = man_sel;
      nxt_valid = locked_pad[man_sel];
    end else begin
      case (state)
        ST_MANUAL: begin
          nxt_state = locked_pad[sel_ch] ? ST_TRACK : ST_IDLE;
          nxt_valid = locked_pad[sel_ch];
        end
        ST_TRACK: begin
          if (!locked_pad[sel_ch]) begin
            if (any_locked) begin
              nxt_sel   = lowest_sel;
              nxt_valid = 1'b1;
            end else begin
              nxt_state = ST_IDLE;
              nxt_valid = 1'b0;
            end
          end
        end
        default: begin
          nxt_valid = any_locked;
          if (any_locked) begin
            nxt_state = ST_TRACK;
            nxt_sel   = lowest_sel;
          end
        end
      endcase
    end
  end

  // Registered selector outputs and switch strobe
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= ST_IDLE;
      sel_ch     <= '0;
      sel_valid  <= 1'b0;
      sel_switch <= 1'b0;
    end else begin
      state      <= nxt_state;
      sel_ch     <= nxt_sel;
      sel_valid  <= nxt_valid;
      sel_switch <= (nxt_sel != sel_ch) || (nxt_valid && !sel_valid);
    end
  end

endmodule
